// File: rtl/pcm_i2s_frame_packer.sv
// Packs a little-endian PCM byte stream (16- or 24-bit stereo) into 64-bit
// MSB-aligned frame words {left_slot, right_slot} for the I2S audio FIFO.
module pcm_i2s_frame_packer #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [7:0]       i_byte_data,
   input  logic             i_byte_valid,
   input  logic             i_frame_start,
   output logic             o_byte_ready,
   input  logic             i_sample_fmt,
   input  logic             i_mute,
   output logic             o_fifo_wr_en,
   output logic [63:0]      o_fifo_wdata,
   input  logic             i_fifo_full,
   output logic [CNT_W-1:0] o_frame_cnt,
   output logic [CNT_W-1:0] o_resync_cnt
);

   logic [2:0]       idx_q, idx_d;
   logic             pending_q, pending_d;
   logic             fmt_q, fmt_d;
   logic [23:0]      left_q, left_d;
   logic [23:0]      right_q, right_d;
   logic             wr_en_q, wr_en_d;
   logic [63:0]      wdata_q, wdata_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] resync_cnt_q, resync_cnt_d;

   logic             byte_accept;
   logic             restart;
   logic             frame_fmt;
   logic [2:0]       cur_idx;
   logic [2:0]       last_idx;
   logic [31:0]      left_slot;
   logic [31:0]      right_slot;

   // Ready comes straight from the pending flag, so accept and write never
   // collide on the same edge and the FIFO full flag never reaches o_byte_ready.
   assign byte_accept = i_byte_valid && !pending_q;

   // The format is captured on the first byte of a frame and held until its end.
   assign restart   = i_frame_start || (idx_q == 3'd0);
   assign frame_fmt = restart ? i_sample_fmt : fmt_q;
   assign cur_idx   = i_frame_start ? 3'd0 : idx_q;
   assign last_idx  = frame_fmt ? 3'd5 : 3'd3;

   assign left_slot  = fmt_q ? {left_q, 8'h00}  : {left_q[15:0], 16'h0000};
   assign right_slot = fmt_q ? {right_q, 8'h00} : {right_q[15:0], 16'h0000};

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path through this block can infer a latch.
      idx_d        = idx_q;
      pending_d    = pending_q;
      fmt_d        = fmt_q;
      left_d       = left_q;
      right_d      = right_q;
      wr_en_d      = 1'b0;
      wdata_d      = wdata_q;
      frame_cnt_d  = frame_cnt_q;
      resync_cnt_d = resync_cnt_q;

      if (byte_accept) begin
         if (restart) begin
            fmt_d = i_sample_fmt;
         end
         if (i_frame_start && (idx_q != 3'd0)) begin
            resync_cnt_d = resync_cnt_q + CNT_W'(1);
         end

         case ({frame_fmt, cur_idx})
            4'b0_000: left_d[7:0]    = i_byte_data;
            4'b0_001: left_d[15:8]   = i_byte_data;
            4'b0_010: right_d[7:0]   = i_byte_data;
            4'b0_011: right_d[15:8]  = i_byte_data;
            4'b1_000: left_d[7:0]    = i_byte_data;
            4'b1_001: left_d[15:8]   = i_byte_data;
            4'b1_010: left_d[23:16]  = i_byte_data;
            4'b1_011: right_d[7:0]   = i_byte_data;
            4'b1_100: right_d[15:8]  = i_byte_data;
            4'b1_101: right_d[23:16] = i_byte_data;
            default: ;
         endcase

         if (cur_idx == last_idx) begin
            pending_d = 1'b1;
            idx_d     = 3'd0;
         end else begin
            idx_d = cur_idx + 3'd1;
         end
      end

      if (pending_q && !i_fifo_full) begin
         wr_en_d     = 1'b1;
         wdata_d     = i_mute ? 64'd0 : {left_slot, right_slot};
         pending_d   = 1'b0;
         frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         idx_q        <= 3'd0;
         pending_q    <= 1'b0;
         fmt_q        <= 1'b0;
         left_q       <= 24'd0;
         right_q      <= 24'd0;
         wr_en_q      <= 1'b0;
         wdata_q      <= 64'd0;
         frame_cnt_q  <= '0;
         resync_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values regardless of statement order.
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         fmt_q        <= fmt_d;
         left_q       <= left_d;
         right_q      <= right_d;
         wr_en_q      <= wr_en_d;
         wdata_q      <= wdata_d;
         frame_cnt_q  <= frame_cnt_d;
         resync_cnt_q <= resync_cnt_d;
      end
   end

   assign o_byte_ready = !pending_q;
   assign o_fifo_wr_en = wr_en_q;
   assign o_fifo_wdata = wdata_q;
   assign o_frame_cnt  = frame_cnt_q;
   assign o_resync_cnt = resync_cnt_q;

endmodule

// File: tb/tb_pcm_i2s_frame_packer.sv
// Scoreboard bench for pcm_i2s_frame_packer: expected frame words are queued
// as bytes are sent and compared whenever the DUT strobes a FIFO write.
module tb_pcm_i2s_frame_packer;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [7:0]       byte_data = 8'd0;
   logic             byte_valid = 1'b0;
   logic             frame_start = 1'b0;
   logic             byte_ready;
   logic             sample_fmt = 1'b0;
   logic             mute = 1'b0;
   logic             fifo_wr_en;
   logic [63:0]      fifo_wdata;
   logic             fifo_full = 1'b0;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] resync_cnt;

   logic [63:0]      exp_q[$];
   logic [63:0]      mon_exp;
   int               checks = 0;
   int               errors = 0;
   int               frames_exp = 0;
   int               resync_exp = 0;

   always #5 clk = ~clk;

   pcm_i2s_frame_packer #(.CNT_W(CNT_W)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_byte_data   (byte_data),
      .i_byte_valid  (byte_valid),
      .i_frame_start (frame_start),
      .o_byte_ready  (byte_ready),
      .i_sample_fmt  (sample_fmt),
      .i_mute        (mute),
      .o_fifo_wr_en  (fifo_wr_en),
      .o_fifo_wdata  (fifo_wdata),
      .i_fifo_full   (fifo_full),
      .o_frame_cnt   (frame_cnt),
      .o_resync_cnt  (resync_cnt)
   );

   // Reference packing: bytes[7:0] is byte 0 of the frame.
   function automatic logic [63:0] model(input logic fmt, input logic [47:0] b, input logic m);
      if (m) return 64'd0;
      if (!fmt) return {b[15:8], b[7:0], 16'h0000, b[31:24], b[23:16], 16'h0000};
      return {b[23:16], b[15:8], b[7:0], 8'h00, b[47:40], b[39:32], b[31:24], 8'h00};
   endfunction

   always @(negedge clk) begin
      if (!rst && fifo_wr_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: wdata=%h with no frame expected", fifo_wdata);
         end else begin
            mon_exp = exp_q.pop_front();
            if (fifo_wdata !== mon_exp) begin
               errors++;
               $display("FAIL wdata: got %h expected %h", fifo_wdata, mon_exp);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      byte_valid = 1'b0;
      frame_start = 1'b0;
      fifo_full = 1'b0;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      frames_exp = 0;
      resync_exp = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic fs, input logic fmt);
      int n = 0;
      @(negedge clk);
      while (!byte_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: ready=%b expected 1 within 200 cycles", byte_ready);
      end
      byte_data = b;
      frame_start = fs;
      sample_fmt = fmt;
      byte_valid = 1'b1;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic send_frame(input logic fmt, input logic [47:0] bytes, input logic fs_first,
                             input logic scramble_fmt);
      int nb;
      logic f;
      exp_q.push_back(model(fmt, bytes, mute));
      frames_exp++;
      nb = fmt ? 6 : 4;
      for (int i = 0; i < nb; i++) begin
         f = (i == 0 || !scramble_fmt) ? fmt : 1'($urandom_range(0, 1));
         send_byte(bytes[8*i +: 8], (i == 0) && fs_first, f);
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d frames outstanding, expected 0", name, exp_q.size());
      end
      checks++;
      if (frame_cnt !== CNT_W'(frames_exp)) begin
         errors++;
         $display("FAIL %s_frame_cnt: got %0d expected %0d", name, frame_cnt, frames_exp);
      end
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if ({byte_ready, fifo_wr_en, fifo_wdata, frame_cnt, resync_cnt} !==
          {1'b1, 1'b0, 64'd0, {CNT_W{1'b0}}, {CNT_W{1'b0}}}) begin
         errors++;
         $display("FAIL %s: ready=%b wr_en=%b wdata=%h frame_cnt=%0d resync_cnt=%0d expected 1 0 0 0 0",
                  name, byte_ready, fifo_wr_en, fifo_wdata, frame_cnt, resync_cnt);
      end
   endtask

   task automatic test_reset();
      apply_reset(2);
      check_reset_values("reset_state");
   endtask

   task automatic test_fmt0_basic();
      exp_q.push_back(64'h2211_0000_4433_0000);
      frames_exp++;
      send_byte(8'h11, 1'b0, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0);
      send_byte(8'h33, 1'b0, 1'b0);
      send_byte(8'h44, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (byte_ready !== 1'b0 || fifo_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL fmt0_pending: ready=%b wr_en=%b expected 0 0", byte_ready, fifo_wr_en);
      end
      @(negedge clk);
      checks++;
      if (byte_ready !== 1'b1 || fifo_wr_en !== 1'b1) begin
         errors++;
         $display("FAIL fmt0_write_cycle: ready=%b wr_en=%b expected 1 1", byte_ready, fifo_wr_en);
      end
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL fmt0_single_pulse: wr_en=%b expected 0", fifo_wr_en);
      end
      wait_drain("fmt0_basic");
   endtask

   task automatic test_fmt1_random();
      logic [47:0] bytes;
      apply_reset(1);
      exp_q.push_back(64'h0302_0100_0605_0400);
      frames_exp++;
      for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0, 1'b1);
      for (int k = 0; k < 100; k++) begin
         bytes = {$urandom(), $urandom()};
         send_frame(1'($urandom_range(0, 1)), bytes, 1'($urandom_range(0, 1)), 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain("fmt1_random");
      checks++;
      if (frame_cnt !== CNT_W'(101) || resync_cnt !== CNT_W'(0)) begin
         errors++;
         $display("FAIL fmt1_counts: frame_cnt=%0d resync_cnt=%0d expected 101 0", frame_cnt, resync_cnt);
      end
   endtask

   task automatic test_fifo_full();
      fifo_full = 1'b1;
      send_frame(1'b0, 48'h0000_DDCC_BBAA, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (byte_ready !== 1'b0 || fifo_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL full_hold_%0d: ready=%b wr_en=%b expected 0 0", i, byte_ready, fifo_wr_en);
         end
         byte_data = 8'hEE;
         frame_start = 1'b1;
         byte_valid = 1'b1;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      frame_start = 1'b0;
      fifo_full = 1'b0;
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b1) begin
         errors++;
         $display("FAIL full_release_write: wr_en=%b expected 1", fifo_wr_en);
      end
      checks++;
      if (resync_cnt !== CNT_W'(resync_exp)) begin
         errors++;
         $display("FAIL full_ignored_start: resync_cnt=%0d expected %0d", resync_cnt, resync_exp);
      end
      send_frame(1'b1, 48'h6655_4433_2211, 1'b0, 1'b0);
      wait_drain("fifo_full");
   endtask

   task automatic test_resync();
      send_byte(8'hA1, 1'b0, 1'b0);
      send_byte(8'hA2, 1'b0, 1'b0);
      resync_exp++;
      send_frame(1'b0, 48'h0000_7856_3412, 1'b1, 1'b0);
      wait_drain("resync");
      checks++;
      if (resync_cnt !== CNT_W'(resync_exp)) begin
         errors++;
         $display("FAIL resync_cnt: got %0d expected %0d", resync_cnt, resync_exp);
      end
      send_frame(1'b1, 48'hF6F5_F4F3_F2F1, 1'b1, 1'b0);
      wait_drain("resync_idx0");
      checks++;
      if (resync_cnt !== CNT_W'(resync_exp)) begin
         errors++;
         $display("FAIL resync_idx0_cnt: got %0d expected %0d", resync_cnt, resync_exp);
      end
   endtask

   task automatic test_mute();
      mute = 1'b1;
      send_frame(1'b1, 48'h1234_5678_9ABC, 1'b0, 1'b0);
      wait_drain("mute");
      mute = 1'b0;
      send_frame(1'b0, 48'h0000_0D0C_0B0A, 1'b0, 1'b0);
      wait_drain("unmute");
   endtask

   task automatic test_reset_pending();
      fifo_full = 1'b1;
      send_frame(1'b0, 48'h0000_4321_8765, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (byte_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_pending_setup: ready=%b expected 0", byte_ready);
      end
      apply_reset(1);
      check_reset_values("rst_pending_state");
      repeat (3) @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b0 || frame_cnt !== CNT_W'(0)) begin
         errors++;
         $display("FAIL rst_pending_no_write: wr_en=%b frame_cnt=%0d expected 0 0", fifo_wr_en, frame_cnt);
      end
      send_frame(1'b1, 48'hCAFE_BABE_BEEF, 1'b0, 1'b0);
      wait_drain("after_reset");
   endtask

   initial begin
      test_reset();
      test_fmt0_basic();
      test_fmt1_random();
      test_fifo_full();
      test_resync();
      test_mute();
      test_reset_pending();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcm_i2s_frame_packer.md
Name: pcm_i2s_frame_packer

Overview:
Upstream neighbour of the CS4334 I2S transmitter. Takes the unpacked PCM byte stream from the pcs_unpack path and assembles little-endian stereo samples (16- or 24-bit) into 64-bit frames: left channel MSB-aligned in [63:32], right channel MSB-aligned in [31:0]. Writes one 64-bit word per stereo frame into the audio FIFO that the transmitter drains on every LRCLK rising edge. Provides byte-level backpressure, frame re-alignment and status counters.

Parameters:
CNT_W, 16, width of the frame and resync counters

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_byte_data  in  8  PCM byte
i_byte_valid  in  1  byte present
i_frame_start  in  1  qualifies current byte as byte 0 of a stereo frame
o_byte_ready  out  1  packer can accept a byte this cycle
i_sample_fmt  in  1  0 = 16-bit stereo (4 bytes/frame), 1 = 24-bit stereo (6 bytes/frame)
i_mute  in  1  write zero samples instead of assembled data
o_fifo_wr_en  out  1  one-cycle FIFO write strobe
o_fifo_wdata  out  64  frame word, valid with o_fifo_wr_en
i_fifo_full  in  1  FIFO full, no write allowed
o_frame_cnt  out  CNT_W  frames written, wraps
o_resync_cnt  out  CNT_W  partial frames discarded by i_frame_start, wraps

Behaviour:
- Single clock domain; all state updates on rising i_clk. i_rst synchronous, active-high, overrides everything.
- Reset values: o_byte_ready=1, o_fifo_wr_en=0, o_fifo_wdata=0, o_frame_cnt=0, o_resync_cnt=0, byte index=0, pending flag=0, assembly registers=0, latched format=0.
- Accept: a byte is taken on an edge where i_byte_valid && o_byte_ready.
- o_byte_ready = !pending (registered flag; no combinational path from i_fifo_full).
- Byte index idx counts 0..N-1, where N=4 (fmt 0) or N=6 (fmt 1). i_sample_fmt is sampled only when a byte is accepted at idx=0 (or with i_frame_start) and held for that frame; changes mid-frame are ignored.
- Byte order, fmt 0: L[7:0], L[15:8], R[7:0], R[15:8]; slot = {sample16, 16'h0000}.
- Byte order, fmt 1: L[7:0], L[15:8], L[23:16], R[7:0], R[15:8], R[23:16]; slot = {sample24, 8'h00}.
- o_fifo_wdata = {left_slot, right_slot}; no sign extension is needed because samples are MSB-aligned.
- Accepting byte N-1 sets pending=1 and idx=0 at that edge.
- Write: on any edge where pending=1 and i_fifo_full=0: o_fifo_wr_en=1 for exactly one cycle, o_fifo_wdata loaded (all zeros if i_mute=1 in that cycle), pending=0, o_frame_cnt+1 (wraps to 0 at all-ones).
- Otherwise o_fifo_wr_en=0; o_fifo_wdata holds its last value.
- Latency: last byte accepted at edge k, then o_fifo_wr_en high in the cycle following edge k+1 (FIFO not full). Ready is low for exactly one cycle per frame at minimum.
- FIFO full: pending stays 1, o_byte_ready stays 0, and no bytes are lost; write occurs on the first edge with i_fifo_full=0.
- i_frame_start on an accepted byte: the byte is stored as byte 0, idx=1. If idx was non-zero beforehand, the partial frame is discarded and o_resync_cnt increments (wraps). i_frame_start at idx=0 has no counter effect.
- i_frame_start or i_byte_valid while pending=1: ignored, because ready=0 and the byte is not accepted.
- i_mute affects only the data written; counting and handshake are unchanged.
- Reset mid-frame or while pending: partial and pending frames are dropped, no write is issued, counters clear.

Test Plan:
- fmt0, bytes 11 22 33 44 back-to-back, FIFO empty -> one wr_en pulse, wdata=64'h2211_0000_4433_0000; ready low 1 cycle; o_frame_cnt=1.
- fmt1, bytes 01 02 03 04 05 06 -> wdata=64'h0302_0100_0605_0400; then 100 random frames are checked against a model, with o_frame_cnt=101.
- fmt0 frame completed while i_fifo_full=1 for 10 cycles -> ready=0 and wr_en=0 throughout; single write 1 cycle after full drops; no byte lost.
- 2 bytes of a frame, then a byte with i_frame_start=1 plus 3 more bytes -> o_resync_cnt=1, one write containing only the new frame.
- i_mute=1 during the write cycle -> wdata=0, wr_en pulses, o_frame_cnt increments.
- i_rst=1 for 1 cycle with pending=1 -> no write, all outputs at reset values, next frame packs correctly.
